// File: rtl/mm_job_sequencer_pkg.sv
// Shared defaults, state encoding and element types for the job sequencer (package mm_pkg).
package mm_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int N            = 4;
  localparam int C_DATA_WIDTH = 2*DATA_WIDTH + $clog2(N);
  localparam int WAIT_LIMIT   = 4;

  typedef logic [DATA_WIDTH-1:0]   operand_t;
  typedef logic [C_DATA_WIDTH-1:0] result_t;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    LOAD   = 3'd1,
    FEED   = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mm_job_sequencer_operand_buf.sv
// N-entry A-column / B-row store for one job: one write port, one zero-padding read port.
module mm_operand_buf
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
  parameter int N          = mm_pkg::N,
  parameter int WR_W       = (N > 1) ? $clog2(N) : 1,
  parameter int RD_W       = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           wr_en_i,
  input  logic [WR_W-1:0]                wr_idx_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_a_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_b_i,
  input  logic [RD_W-1:0]                rd_idx_i,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_a_o,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_b_o
);

  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_mem_q;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_mem_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_mem_q <= '0;
      b_mem_q <= '0;
    end else if (wr_en_i) begin
      a_mem_q[wr_idx_i] <= wr_a_i;
      b_mem_q[wr_idx_i] <= wr_b_i;
    end
  end

  // Indices past the last beat read as zero: that is the skew padding.
  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    if (rd_idx_i < RD_W'(N)) begin
      rd_a_o = a_mem_q[rd_idx_i[WR_W-1:0]];
      rd_b_o = b_mem_q[rd_idx_i[WR_W-1:0]];
    end else begin
      rd_a_o = '0;
      rd_b_o = '0;
    end
  end

endmodule

// File: rtl/mm_job_sequencer.sv
// Job controller for the NxN sum-stationary systolic multiplier: load, feed, capture, present.
// Optional cycle counter port perf_cycles_o is built when MM_SEQ_PERF_EN is defined.
module mm_job_sequencer
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH   = mm_pkg::DATA_WIDTH,
  parameter int N            = mm_pkg::N,
  parameter int C_DATA_WIDTH = 2*DATA_WIDTH + $clog2(N),
  parameter int WAIT_LIMIT   = mm_pkg::WAIT_LIMIT
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]       in_a_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]       in_b_i,
  output logic                               arr_reset_o,
  output logic                               arr_valid_o,
  output logic [N-1:0][DATA_WIDTH-1:0]       arr_a_o,
  output logic [N-1:0][DATA_WIDTH-1:0]       arr_b_o,
  input  logic                               arr_valid_i,
  input  logic [N*N-1:0][C_DATA_WIDTH-1:0]   arr_c_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [N*N-1:0][C_DATA_WIDTH-1:0]   out_c_o,
  output logic                               busy_o,
  output logic                               err_o
`ifdef MM_SEQ_PERF_EN
  ,output logic [15:0]                       perf_cycles_o
`endif
);

  localparam int FEED_LEN = 3*N - 2;
  localparam int FCW      = $clog2(FEED_LEN + 1);
  localparam int BCW      = (N > 1) ? $clog2(N) : 1;
  localparam int WCW      = $clog2(WAIT_LIMIT + 1);

  seq_state_e                           state_q, state_d;
  logic [BCW-1:0]                       beat_cnt_q, beat_cnt_d;
  logic [FCW-1:0]                       feed_cnt_q, feed_cnt_d;
  logic [WCW-1:0]                       wait_cnt_q, wait_cnt_d;
  logic                                 err_q, err_d;
  logic [N*N-1:0][C_DATA_WIDTH-1:0]     out_c_q, out_c_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 arr_reset_q, arr_reset_d;
  logic                                 arr_valid_q, arr_valid_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 busy_q, busy_d;
  logic [N-1:0][DATA_WIDTH-1:0]         arr_a_q, arr_a_d;
  logic [N-1:0][DATA_WIDTH-1:0]         arr_b_q, arr_b_d;
  logic                                 buf_wr_en;
  logic [N-1:0][DATA_WIDTH-1:0]         buf_rd_a, buf_rd_b;

  mm_operand_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .WR_W       (BCW),
    .RD_W       (FCW)
  ) u_operand_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_en_i    (buf_wr_en),
    .wr_idx_i   (beat_cnt_q),
    .wr_a_i     (in_a_i),
    .wr_b_i     (in_b_i),
    .rd_idx_i   (feed_cnt_d),
    .rd_a_o     (buf_rd_a),
    .rd_b_o     (buf_rd_b)
  );

  // Next-state logic; outputs are decoded from the next state so they leave a flop.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    feed_cnt_d = feed_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    out_c_d    = out_c_q;
    buf_wr_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        state_d    = LOAD;
        beat_cnt_d = '0;
        feed_cnt_d = '0;
        wait_cnt_d = '0;
      end
      LOAD: begin
        if (in_valid_i && in_ready_q) begin
          buf_wr_en = 1'b1;
          if (beat_cnt_q == BCW'(N-1)) begin
            beat_cnt_d = '0;
            feed_cnt_d = '0;
            state_d    = FEED;
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      FEED: begin
        if (feed_cnt_q == FCW'(FEED_LEN-1)) begin
          feed_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          feed_cnt_d = feed_cnt_q + FCW'(1);
        end
      end
      WAIT: begin
        if (arr_valid_i) begin
          out_c_d = arr_c_i;
          state_d = OUTPUT;
        end else if (wait_cnt_q == WCW'(WAIT_LIMIT-1)) begin
          err_d   = 1'b1;
          state_d = CLEAR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      OUTPUT: begin
        if (out_ready_i && out_valid_q) begin
          state_d = CLEAR;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    in_ready_d  = (state_d == LOAD);
    arr_reset_d = (state_d == CLEAR);
    arr_valid_d = (state_d == FEED);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != LOAD);
    if (state_d == FEED) begin
      arr_a_d = buf_rd_a;
      arr_b_d = buf_rd_b;
    end else begin
      arr_a_d = '0;
      arr_b_d = '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= CLEAR;
      beat_cnt_q  <= '0;
      feed_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      out_c_q     <= '0;
      in_ready_q  <= 1'b0;
      arr_reset_q <= 1'b1;
      arr_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      arr_a_q     <= '0;
      arr_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      out_c_q     <= out_c_d;
      in_ready_q  <= in_ready_d;
      arr_reset_q <= arr_reset_d;
      arr_valid_q <= arr_valid_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      arr_a_q     <= arr_a_d;
      arr_b_q     <= arr_b_d;
    end
  end

  // The array must see reset in the same cycle reset_i is raised.
  assign arr_reset_o = arr_reset_q | reset_i;
  assign in_ready_o  = in_ready_q;
  assign arr_valid_o = arr_valid_q;
  assign arr_a_o     = arr_a_q;
  assign arr_b_o     = arr_b_q;
  assign out_valid_o = out_valid_q;
  assign out_c_o     = out_c_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

`ifdef MM_SEQ_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic        perf_run_q, perf_run_d;

  // Job latency counter: restarts on a job's first beat, freezes once the result is presented.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_run_d = perf_run_q;
    if ((state_q == LOAD) && in_valid_i && in_ready_q && (beat_cnt_q == BCW'(0))) begin
      perf_cnt_d = 16'd1;
      perf_run_d = 1'b1;
    end else if (perf_run_q) begin
      if (perf_cnt_q != 16'hFFFF) begin
        perf_cnt_d = perf_cnt_q + 16'd1;
      end else begin
        perf_cnt_d = perf_cnt_q;
      end
      if ((state_d == OUTPUT) || (state_d == CLEAR)) begin
        perf_run_d = 1'b0;
      end else begin
        perf_run_d = 1'b1;
      end
    end else begin
      perf_run_d = 1'b0;
    end
  end

  // Latency counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cnt_q <= 16'd0;
      perf_run_q <= 1'b0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_run_q <= perf_run_d;
    end
  end

  assign perf_cycles_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Self-checking bench for mm_job_sequencer with a behavioural NxN accumulate-array stand-in.
module tb_mm_job_sequencer;
  import mm_pkg::*;

  localparam int NN   = 4;
  localparam int DW   = 8;
  localparam int CW   = 18;
  localparam int FLEN = 3*NN - 2;

  typedef logic [NN*NN-1:0][CW-1:0] cvec_t;
  typedef struct packed {
    logic [NN*NN-1:0][DW-1:0] a;
    logic [NN*NN-1:0][DW-1:0] b;
    cvec_t                    exp;
    logic                     gap;
    logic [7:0]               stall;
  } vec_t;

  logic                       clk_i = 1'b0;
  logic                       reset_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [NN-1:0][DW-1:0]      in_a_i;
  logic [NN-1:0][DW-1:0]      in_b_i;
  logic                       arr_reset_o;
  logic                       arr_valid_o;
  logic [NN-1:0][DW-1:0]      arr_a_o;
  logic [NN-1:0][DW-1:0]      arr_b_o;
  logic                       arr_valid_i;
  cvec_t                      arr_c_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  cvec_t                      out_c_o;
  logic                       busy_o;
  logic                       err_o;
`ifdef MM_SEQ_PERF_EN
  logic [15:0]                perf_cycles_o;
`endif

  mm_job_sequencer dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .arr_reset_o (arr_reset_o),
    .arr_valid_o (arr_valid_o),
    .arr_a_o     (arr_a_o),
    .arr_b_o     (arr_b_o),
    .arr_valid_i (arr_valid_i),
    .arr_c_i     (arr_c_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_c_o     (out_c_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
`ifdef MM_SEQ_PERF_EN
    ,.perf_cycles_o (perf_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Array stand-in: accumulates outer products of every fed beat, reports after FLEN valid cycles.
  cvec_t acc;
  int    vcnt;
  logic  m_valid;
  logic  mute;
  logic  stray;
  always @(posedge clk_i) begin
    if (arr_reset_o) begin
      acc     <= '0;
      vcnt    <= 0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (arr_valid_o) begin
        for (int r = 0; r < NN; r++)
          for (int c = 0; c < NN; c++)
            acc[r*NN+c] <= acc[r*NN+c] + CW'(arr_a_o[r]) * CW'(arr_b_o[c]);
        vcnt <= vcnt + 1;
        if (vcnt == FLEN-1 && !mute) m_valid <= 1'b1;
      end
    end
  end
  assign arr_valid_i = m_valid | stray;
  assign arr_c_i     = stray ? {NN*NN{18'h2AAAA}} : acc;

  int    total = 0;
  int    bad   = 0;
  vec_t  vec [4];
  cvec_t sb [$];
  cvec_t last_c;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic cvec_t gold(input logic [NN*NN-1:0][DW-1:0] a, input logic [NN*NN-1:0][DW-1:0] b);
    cvec_t c = '0;
    for (int r = 0; r < NN; r++)
      for (int j = 0; j < NN; j++)
        for (int k = 0; k < NN; k++)
          c[r*NN+j] = c[r*NN+j] + CW'(a[r*NN+k]) * CW'(b[k*NN+j]);
    return c;
  endfunction

  task automatic send_beats(input int v);
    for (int k = 0; k < NN; k++) begin
      int t;
      if (vec[v].gap && k > 0) begin
        in_valid_i = 1'b0;
        @(negedge clk_i);
      end
      for (int r = 0; r < NN; r++) begin
        in_a_i[r] = vec[v].a[r*NN+k];
        in_b_i[r] = vec[v].b[k*NN+r];
      end
      in_valid_i = 1'b1;
      t = 0;
      while (!in_ready_o && t < 50) begin
        @(negedge clk_i);
        t++;
      end
      chk("beat_accept", 288'(in_ready_o), 288'(1));
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic run_job(input int v);
    int    lat;
    cvec_t exp;
    sb.push_back(vec[v].exp);
    send_beats(v);
    lat = 1;
    while (!out_valid_o && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    chk("latency", 288'(lat), 288'(12));
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("result", 288'(out_c_o), 288'(exp));
    for (int s = 0; s < int'(vec[v].stall); s++) begin
      @(negedge clk_i);
      chk("hold_c", 288'(out_c_o), 288'(exp));
      chk("hold_flags", 288'({out_valid_o, in_ready_o}), 288'(2'b10));
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("clear_after_ack", 288'({arr_reset_o, out_valid_o, in_ready_o}), 288'(3'b100));
    last_c = exp;
  endtask

  initial begin
    int lat;
    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_a_i = '0; in_b_i = '0; mute = 1'b0; stray = 1'b0; last_c = '0;

    for (int i = 0; i < NN*NN; i++) begin
      vec[0].a[i]   = ((i / NN) == (i % NN)) ? 8'd1 : 8'd0;
      vec[0].b[i]   = DW'(i + 1);
      vec[0].exp[i] = CW'(i + 1);
      vec[1].a[i]   = 8'd255;
      vec[1].b[i]   = 8'd255;
      vec[1].exp[i] = 18'd260100;
      vec[2].a[i]   = DW'($urandom_range(0, 255));
      vec[2].b[i]   = DW'($urandom_range(0, 255));
      vec[3].a[i]   = DW'($urandom_range(0, 255));
      vec[3].b[i]   = DW'($urandom_range(0, 255));
    end
    vec[0].gap = 1'b0; vec[0].stall = 8'd0;
    vec[1].gap = 1'b0; vec[1].stall = 8'd0;
    vec[2].gap = 1'b1; vec[2].stall = 8'd0; vec[2].exp = gold(vec[2].a, vec[2].b);
    vec[3].gap = 1'b0; vec[3].stall = 8'd20; vec[3].exp = gold(vec[3].a, vec[3].b);

    repeat (3) @(negedge clk_i);
    chk("reset_flags", 288'({arr_reset_o, arr_valid_o, in_ready_o, busy_o, out_valid_o, err_o}), 288'(6'b100100));
    chk("reset_out_c", 288'(out_c_o), 288'(0));
    reset_i = 1'b0;

    for (int v = 0; v < 4; v++) run_job(v);

    // Stray array valid while idle must not be captured.
    stray = 1'b1;
    repeat (2) @(negedge clk_i);
    stray = 1'b0;
    @(negedge clk_i);
    chk("stray_ignored_c", 288'(out_c_o), 288'(last_c));
    chk("stray_ignored_flags", 288'({out_valid_o, in_ready_o}), 288'(2'b01));

    // Reset pulse in the sixth FEED cycle aborts the job.
    send_beats(2);
    repeat (5) @(negedge clk_i);
    chk("feed_active", 288'(arr_valid_o), 288'(1));
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("abort_flags", 288'({arr_reset_o, arr_valid_o, in_ready_o, busy_o, out_valid_o}), 288'(5'b10010));
    chk("abort_out_c", 288'(out_c_o), 288'(0));
    run_job(3);

    // Silent array: timeout after WAIT_LIMIT WAIT cycles.
    mute = 1'b1;
    send_beats(0);
    lat = 1;
    while (!err_o && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    chk("err_latency", 288'(lat), 288'(15));
    chk("err_clear", 288'({arr_reset_o, out_valid_o}), 288'(2'b10));
    @(negedge clk_i);
    chk("err_back_to_load", 288'(in_ready_o), 288'(1));
    mute = 1'b0;
    run_job(1);
    chk("err_sticky", 288'(err_o), 288'(1));
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("err_cleared_by_reset", 288'(err_o), 288'(0));
    run_job(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
